m68k_bus_arbiter: RTL

- Owns 68000 bus-mastership arbitration for the PiStorm CPLD.
- Implements the BR_n/BG_n/BGACK_n protocol, so external DMA masters (Zorro cards) can take the bus between local cycles.
- Sits between the Pi-side front end (op_req) and the 68k bus-cycle sequencer (op_go, cycle_busy).
- Drives the release signal that tri-states AS/UDS/LDS/RW/FC and the address-latch OE.

---
 rtl/m68k_arb_pkg.sv | 15 +
 rtl/arb_sync.sv | 28 ++
 rtl/m68k_bus_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/m68k_arb_pkg.sv
// Shared types and default constants for the 68000 bus-mastership arbiter.
package m68k_arb_pkg;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int GRANT_TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF         = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        EXT     = 2'd2,
        RECLAIM = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_sync.sv
// Multi-flop single-bit synchronizer for active-low bus inputs; resets to the inactive level (1).
module arb_sync #(
    parameter int STAGES = 2
) (
    input  logic c200m,
    input  logic reset,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge c200m) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 BR_n/BG_n/BGACK_n bus-mastership arbiter between the local sequencer and external DMA masters.
// Optional grant/timeout statistics counters are built when M68K_ARB_STATS_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | local side owns the bus, decisions on c7m falling edges
//   GRANT   | BG_n asserted, local drivers released, waiting for BGACK_n
//   EXT     | external master owns the bus (BGACK_n low)
//   RECLAIM | BGACK_n released, half-clock turnaround before driving again
module m68k_bus_arbiter
    import m68k_arb_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
`ifdef M68K_ARB_STATS_EN
    ,
    parameter int CNT_W         = CNT_W_DEF
`endif
) (
    input  logic             c200m,
    input  logic             reset,
    input  logic             c7m_rising,
    input  logic             c7m_falling,
    input  logic             m68k_br_n,
    input  logic             m68k_bgack_n,
    input  logic             op_req,
    input  logic             cycle_busy,
    output logic             op_go,
    output logic             m68k_bg_n,
    output logic             bus_release,
    output logic             ext_owned,
    output logic             op_pending
`ifdef M68K_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_count,
    output logic [7:0]       timeout_count
`endif
);

    localparam int TMR_W = $clog2(GRANT_TIMEOUT + 1);

    logic br_s;
    logic bgack_s;

    arb_state_e       state_q, state_d;
    logic             bg_n_q, bg_n_d;
    logic             release_q, release_d;
    logic             ext_q, ext_d;
    logic             last_ext_q, last_ext_d;
    logic             op_go_q, op_go_d;
    logic             op_pending_q, op_pending_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             idle_ok;

    arb_sync #(.STAGES(SYNC_STAGES)) u_sync_br (
        .c200m (c200m),
        .reset (reset),
        .d_in  (m68k_br_n),
        .q_out (br_s)
    );

    arb_sync #(.STAGES(SYNC_STAGES)) u_sync_bgack (
        .c200m (c200m),
        .reset (reset),
        .d_in  (m68k_bgack_n),
        .q_out (bgack_s)
    );

    // op_go_q guard keeps a second decision from landing before cycle_busy rises
    assign idle_ok = c7m_falling && !cycle_busy && !op_go_q;

    always_comb begin
        state_d      = state_q;
        bg_n_d       = bg_n_q;
        release_d    = release_q;
        ext_d        = ext_q;
        last_ext_d   = last_ext_q;
        tmr_d        = tmr_q;
        op_go_d      = 1'b0;
        op_pending_d = op_pending_q | op_req;

        case (state_q)
            IDLE: begin
                if (idle_ok) begin
                    // a local op waiting after an external tenure wins over a fresh BR
                    if (op_pending_q && (br_s || last_ext_q)) begin
                        op_go_d    = 1'b1;
                        last_ext_d = 1'b0;
                    end else if (!br_s) begin
                        bg_n_d    = 1'b0;
                        release_d = 1'b1;
                        tmr_d     = TMR_W'(GRANT_TIMEOUT);
                        state_d   = GRANT;
                    end
                end
            end
            GRANT: begin
                if (!bgack_s) begin
                    bg_n_d  = 1'b1;
                    ext_d   = 1'b1;
                    state_d = EXT;
                end else if (br_s) begin
                    bg_n_d    = 1'b1;
                    release_d = 1'b0;
                    state_d   = IDLE;
                end else if (c7m_falling) begin
                    if (tmr_q == TMR_W'(1)) begin
                        tmr_d     = '0;
                        bg_n_d    = 1'b1;
                        release_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
            end
            EXT: begin
                if (bgack_s) begin
                    ext_d      = 1'b0;
                    last_ext_d = 1'b1;
                    state_d    = RECLAIM;
                end
            end
            RECLAIM: begin
                if (c7m_rising) begin
                    release_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (op_go_d) begin
            op_pending_d = 1'b0;
        end
    end

    always_ff @(posedge c200m) begin
        if (reset) begin
            state_q      <= IDLE;
            bg_n_q       <= 1'b1;
            release_q    <= 1'b0;
            ext_q        <= 1'b0;
            last_ext_q   <= 1'b0;
            op_go_q      <= 1'b0;
            op_pending_q <= 1'b0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            bg_n_q       <= bg_n_d;
            release_q    <= release_d;
            ext_q        <= ext_d;
            last_ext_q   <= last_ext_d;
            op_go_q      <= op_go_d;
            op_pending_q <= op_pending_d;
            tmr_q        <= tmr_d;
        end
    end

    assign op_go       = op_go_q;
    assign m68k_bg_n   = bg_n_q;
    assign bus_release = release_q;
    assign ext_owned   = ext_q;
    assign op_pending  = op_pending_q;

`ifdef M68K_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [7:0]       timeout_cnt_q, timeout_cnt_d;
    logic             grant_inc;
    logic             timeout_inc;

    always_comb begin
        grant_inc     = (state_q == EXT) && (state_d == RECLAIM);
        // leaving GRANT to IDLE with BR still low and no BGACK can only be the timeout
        timeout_inc   = (state_q == GRANT) && (state_d == IDLE) && bgack_s && !br_s;
        grant_cnt_d   = grant_inc ? grant_cnt_q + CNT_W'(1) : grant_cnt_q;
        timeout_cnt_d = (timeout_inc && (timeout_cnt_q != 8'hFF)) ? timeout_cnt_q + 8'd1
                                                                   : timeout_cnt_q;
    end

    always_ff @(posedge c200m) begin
        if (reset) begin
            grant_cnt_q   <= '0;
            timeout_cnt_q <= '0;
        end else begin
            grant_cnt_q   <= grant_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign grant_count   = grant_cnt_q;
    assign timeout_count = timeout_cnt_q;
`endif

endmodule
